// File: rtl/ysyx_24080014_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding
// environment (fetch stage, load/store stage and downstream memory together).
//
// Handshake rule used on every request channel in this bundle:
//   A request moves when valid && ready are both high at a rising clock edge.
//   The ready signal may depend combinationally on valid.
//   Response valids are single-cycle pulses with no back-pressure.
//   Data fields travel with their valid.
interface ysyx_24080014_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 8
);
   logic          ifu_req_valid;
   logic          ifu_req_ready;
   logic [AW-1:0] ifu_addr;
   logic          ifu_resp_valid;
   logic [DW-1:0] ifu_rdata;

   logic          lsu_req_valid;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_addr;
   logic          lsu_wen;
   logic [DW-1:0] lsu_wdata;
   logic [MW-1:0] lsu_wmask;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_rdata;

   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_rdata;

   logic          arb_grant;   // current owner: 0=IFU, 1=LSU
   logic [1:0]    arb_state;   // FSM state, for debug and checkers

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output arb_grant, arb_state
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  arb_grant, arb_state
   );
endinterface

// File: rtl/ysyx_24080014_mem_arbiter.sv
// Memory arbiter: shares one memory port between IFU (read-only) and LSU.
// One transaction in flight: IDLE (grant) -> REQ (downstream request) -> RESP
// (wait for downstream response, forward it to the owner) -> IDLE.
// Default arbitration is fixed LSU-over-IFU priority. Defining the macro
// YSYX_24080014_ARB_RR_EN switches ties to round-robin using last_grant.
module ysyx_24080014_mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_24080014_mem_arbiter_if.slave        bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic          wen_q;
   logic [DW-1:0] wdata_q;
   logic [MW-1:0] wmask_q;
   logic          grant_q;
   logic          req_valid_q;

   logic          is_idle;
   logic          pick_lsu;
   logic          hs_ifu;
   logic          hs_lsu;
   logic          resp_fire;

   assign is_idle = (state == S_IDLE);

`ifdef YSYX_24080014_ARB_RR_EN
   logic last_grant;

   // On a tie the requester that did not win last time goes first.
   assign pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_grant);

   // Remember the owner of the most recent handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b0;
      end else if (hs_lsu || hs_ifu) begin
         last_grant <= hs_lsu;
      end
   end
`else
   // LSU always wins a tie; a lone IFU request still gets through.
   assign pick_lsu = bus.lsu_req_valid;
`endif

   // Readies are only offered in IDLE and only to the arbitration winner.
   assign bus.lsu_req_ready = is_idle && pick_lsu;
   assign bus.ifu_req_ready = is_idle && bus.ifu_req_valid && !pick_lsu;

   assign hs_lsu = bus.lsu_req_valid && bus.lsu_req_ready;
   assign hs_ifu = bus.ifu_req_valid && bus.ifu_req_ready;

   // Downstream response only counts while waiting for it.
   assign resp_fire = (state == S_RESP) && bus.mem_resp_valid;

   assign bus.ifu_resp_valid = resp_fire && !grant_q;
   assign bus.lsu_resp_valid = resp_fire && grant_q;
   assign bus.ifu_rdata      = bus.ifu_resp_valid ? bus.mem_rdata : '0;
   assign bus.lsu_rdata      = bus.lsu_resp_valid ? bus.mem_rdata : '0;

   // Downstream request fields come straight from the latched registers, so
   // they stay put no matter what the requester does after its handshake.
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wen       = wen_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_wmask     = wmask_q;

   assign bus.arb_grant = grant_q;
   assign bus.arb_state = state;

   // Transaction sequencer: latch the winner's request, issue it, await the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         grant_q     <= 1'b0;
         req_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hs_lsu) begin
                  addr_q      <= bus.lsu_addr;
                  wen_q       <= bus.lsu_wen;
                  wdata_q     <= bus.lsu_wdata;
                  wmask_q     <= bus.lsu_wmask;
                  grant_q     <= 1'b1;
                  req_valid_q <= 1'b1;
                  state       <= S_REQ;
               end else if (hs_ifu) begin
                  addr_q      <= bus.ifu_addr;
                  wen_q       <= 1'b0;
                  wdata_q     <= '0;
                  wmask_q     <= '0;
                  grant_q     <= 1'b0;
                  req_valid_q <= 1'b1;
                  state       <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  req_valid_q <= 1'b0;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.mem_resp_valid) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               req_valid_q <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Bench for ysyx_24080014_mem_arbiter. Honours YSYX_24080014_ARB_RR_EN when defined.
// A downstream memory responder runs alongside the directed/random request sequence.
// Expected grant order and read data come from a simple memory/arbitration model.
module tb_ysyx_24080014_mem_arbiter;

`ifdef YSYX_24080014_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } mreq_t;

   typedef struct packed {
      logic        who;    // 0=IFU, 1=LSU
      logic        wen;
      logic [31:0] data;
   } mresp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ysyx_24080014_mem_arbiter_if bus ();

   ysyx_24080014_mem_arbiter u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   mreq_t  exp_req_q[$];
   mresp_t exp_resp_q[$];
   logic   exp_grant_q[$];

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dn_mem  [logic [31:0]];
   logic        last_m = 1'b0;

   bit auto_mem   = 1'b0;
   int req_delay  = 0;
   int resp_delay = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return (a * 32'h9e37_79b1) ^ 32'h5a5a_1234;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [7:0] wm);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a] = d;
      dn_mem[a]  = d;
   endtask

   // reference model: record one granted access in grant order
   task automatic model_push(input logic who, input logic [31:0] a, input logic wen,
                             input logic [31:0] wd, input logic [7:0] wm);
      logic [31:0] cur;
      cur = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
      exp_req_q.push_back('{addr: a, wen: wen, wdata: wd, wmask: wm});
      exp_resp_q.push_back('{who: who, wen: wen, data: wen ? 32'h0 : cur});
      if (wen) ref_mem[a] = merge(cur, wd, wm);
      exp_grant_q.push_back(who);
      last_m = who;
   endtask

   // downstream memory responder
   initial begin
      mreq_t cap;
      mreq_t e;
      logic [31:0] cur;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (auto_mem && !rst && bus.mem_req_valid) begin
            cap = '{addr: bus.mem_addr, wen: bus.mem_wen, wdata: bus.mem_wdata, wmask: bus.mem_wmask};
            if (exp_req_q.size() == 0) begin
               chk("unexpected_mem_req", 32'(exp_req_q.size()), 32'd1);
            end else begin
               e = exp_req_q.pop_front();
               chk("mem_addr", cap.addr, e.addr);
               chk("mem_wen", 32'(cap.wen), 32'(e.wen));
               chk("mem_wmask", 32'(cap.wmask), 32'(e.wmask));
               if (e.wen) chk("mem_wdata", cap.wdata, e.wdata);
            end
            for (int k = 0; k < req_delay; k++) begin
               @(posedge clk); #1;
               chk("hold_req_valid", 32'(bus.mem_req_valid), 32'd1);
               chk("hold_addr", bus.mem_addr, cap.addr);
               chk("hold_wen", 32'(bus.mem_wen), 32'(cap.wen));
               chk("hold_wdata", bus.mem_wdata, cap.wdata);
               chk("hold_wmask", 32'(bus.mem_wmask), 32'(cap.wmask));
            end
            bus.mem_req_ready = 1'b1;
            @(posedge clk); #1;
            bus.mem_req_ready = 1'b0;
            chk("req_valid_drop", 32'(bus.mem_req_valid), 32'd0);
            for (int k = 0; k < resp_delay; k++) begin
               @(posedge clk); #1;
            end
            cur = dn_mem.exists(cap.addr) ? dn_mem[cap.addr] : mem_init(cap.addr);
            if (cap.wen) begin
               dn_mem[cap.addr] = merge(cur, cap.wdata, cap.wmask);
               bus.mem_rdata    = $urandom;
            end else begin
               bus.mem_rdata = cur;
            end
            bus.mem_resp_valid = 1'b1;
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = $urandom;
         end
      end
   end

   // requester driver: IFU and/or LSU raise their request in the same cycle
   task automatic run_txn(input bit do_i, input bit do_l, input logic [31:0] ia,
                          input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                          input logic [7:0] lwm);
      int n = 0;
      int done = 0;
      int outstanding = 0;
      int hs_cyc = 0;
      bit pend_i = do_i;
      bit pend_l = do_l;
      bit lsu_first;
      bit has;
      bit hs_i;
      bit hs_l;
      logic nxt;
      bit min_lat;
      mresp_t e;
      min_lat = (req_delay == 0) && (resp_delay == 0);
      lsu_first = do_l && (!do_i || !RR || !last_m);
      if (lsu_first) begin
         model_push(1'b1, la, lw, lwd, lwm);
         if (do_i) model_push(1'b0, ia, 1'b0, 32'h0, 8'h0);
      end else begin
         if (do_i) model_push(1'b0, ia, 1'b0, 32'h0, 8'h0);
         if (do_l) model_push(1'b1, la, lw, lwd, lwm);
      end
      n = int'(do_i) + int'(do_l);

      @(negedge clk);
      bus.ifu_req_valid = do_i;
      bus.ifu_addr      = ia;
      bus.lsu_req_valid = do_l;
      bus.lsu_addr      = la;
      bus.lsu_wen       = lw;
      bus.lsu_wdata     = lwd;
      bus.lsu_wmask     = lwm;
      for (int c = 0; c < 300 && done < n; c++) begin
         #1;
         has = exp_grant_q.size() != 0;
         nxt = has ? exp_grant_q[0] : 1'b0;
         chk("ifu_req_ready", 32'(bus.ifu_req_ready), 32'(pend_i && outstanding == 0 && has && nxt == 1'b0));
         chk("lsu_req_ready", 32'(bus.lsu_req_ready), 32'(pend_l && outstanding == 0 && has && nxt == 1'b1));
         hs_i = bus.ifu_req_valid && bus.ifu_req_ready;
         hs_l = bus.lsu_req_valid && bus.lsu_req_ready;
         if (hs_i || hs_l) begin
            if (has) void'(exp_grant_q.pop_front());
            outstanding++;
            hs_cyc = c;
         end
         if (hs_i) pend_i = 1'b0;
         if (hs_l) pend_l = 1'b0;
         if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
            if (exp_resp_q.size() == 0) begin
               chk("spurious_resp", 32'(exp_resp_q.size()), 32'd1);
            end else begin
               e = exp_resp_q.pop_front();
               chk("ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'(!e.who));
               chk("lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'(e.who));
               chk("arb_grant", 32'(bus.arb_grant), 32'(e.who));
               if (!e.wen) chk(e.who ? "lsu_rdata" : "ifu_rdata",
                               e.who ? bus.lsu_rdata : bus.ifu_rdata, e.data);
               if (min_lat) chk("min_latency", 32'(c - hs_cyc), 32'd2);
            end
            outstanding--;
            done++;
         end
         @(posedge clk); #1;
         // requester is free to move its inputs once accepted
         if (hs_i) begin
            bus.ifu_req_valid = 1'b0;
            bus.ifu_addr      = $urandom;
         end
         if (hs_l) begin
            bus.lsu_req_valid = 1'b0;
            bus.lsu_addr      = 32'h0;
            bus.lsu_wen       = 1'($urandom_range(0, 1));
            bus.lsu_wdata     = $urandom;
            bus.lsu_wmask     = 8'($urandom);
         end
         @(negedge clk);
      end
      chk("txn_done", 32'(done), 32'(n));
   endtask

   // directed and random steps
   initial begin
      int pat;
      bus.ifu_req_valid = 1'b0;
      bus.ifu_addr      = 32'h0;
      bus.lsu_req_valid = 1'b0;
      bus.lsu_addr      = 32'h0;
      bus.lsu_wen       = 1'b0;
      bus.lsu_wdata     = 32'h0;
      bus.lsu_wmask     = 8'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
      chk("rst_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
      chk("rst_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("rst_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
      chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
      chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
      chk("rst_ifu_rdata", bus.ifu_rdata, 32'h0);
      chk("rst_lsu_rdata", bus.lsu_rdata, 32'h0);
      chk("rst_arb_grant", 32'(bus.arb_grant), 32'd0);
      auto_mem = 1'b1;

      // T1: IFU-only read with fastest downstream
      preload(32'h8000_0000, 32'h0000_0413);
      req_delay = 0; resp_delay = 0;
      run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h0);

      // T2: simultaneous requests
      run_txn(1'b1, 1'b1, 32'h8000_0004, 32'h8000_0008, 1'b0, 32'h0, 8'hff);

      // T3: back-to-back ties
      run_txn(1'b1, 1'b1, 32'h8000_000c, 32'h8000_0010, 1'b0, 32'h0, 8'h0f);
      run_txn(1'b1, 1'b1, 32'h8000_0014, 32'h8000_0018, 1'b1, 32'hcafe_f00d, 8'h03);

      // T4/T5: stalled store, then read the byte back
      req_delay = 5; resp_delay = 1;
      run_txn(1'b0, 1'b1, 32'h0, 32'ha000_03f8, 1'b1, 32'h0000_0041, 8'h01);
      req_delay = 0; resp_delay = 0;
      run_txn(1'b0, 1'b1, 32'h0, 32'ha000_03f8, 1'b0, 32'h0, 8'h00);

      // random mix of IFU-only, LSU-only and simultaneous requests
      for (int it = 0; it < 40; it++) begin
         pat        = $urandom_range(0, 2);
         req_delay  = $urandom_range(0, 3);
         resp_delay = $urandom_range(0, 3);
         run_txn(pat != 1, pat != 0,
                 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4,
                 32'h8000_0000 + 32'($urandom_range(0, 7)) * 32'd4,
                 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
      end

      // T6: reset while waiting for the downstream response
      auto_mem = 1'b0;
      @(negedge clk);
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = 32'h8000_0020;
      bus.lsu_wen       = 1'b0;
      #1;
      chk("t6_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
      @(negedge clk);
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      chk("t6_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      #1;
      chk("t6_in_resp", 32'(bus.arb_state), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_m = 1'b0;
      #1;
      chk("t6_state", 32'(bus.arb_state), 32'd0);
      chk("t6_mem_req_valid_rst", 32'(bus.mem_req_valid), 32'd0);
      chk("t6_mem_addr_rst", bus.mem_addr, 32'h0);
      chk("t6_arb_grant_rst", 32'(bus.arb_grant), 32'd0);
      chk("t6_ifu_ready_rst", 32'(bus.ifu_req_ready), 32'd0);
      chk("t6_lsu_ready_rst", 32'(bus.lsu_req_ready), 32'd0);
      @(negedge clk);
      bus.mem_resp_valid = 1'b1;
      bus.mem_rdata      = 32'h1234_5678;
      #1;
      chk("t6_late_ifu_resp", 32'(bus.ifu_resp_valid), 32'd0);
      chk("t6_late_lsu_resp", 32'(bus.lsu_resp_valid), 32'd0);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      auto_mem = 1'b1;

      // first tie after reset goes to LSU in either arbitration mode
      run_txn(1'b1, 1'b1, 32'h8000_0024, 32'h8000_0028, 1'b0, 32'h0, 8'h0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
